flash_seq_ctrl: RTL

Parametrised SPI-NOR flash test sequencer that drives the byte-level SPI flash driver through a complete erase / program / read-back / compare cycle over a configurable range of pages. It generates write-enable, erase, page-program, read and status-poll commands. It polls the WIP bit instead of relying on fixed ordering, and reports pass/fail and an error count. It sits between the board-level test top and the SPI flash driver, replacing the fixed 11-step command counter.

---
 rtl/flash_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/flash_seq_ctrl.sv
// SPI-NOR flash test sequencer: erase / program / poll / read-back / compare over a page range.
// Each command state has an ISSUE phase (wait for the driver to go idle, pulse spi_start) and a WAIT phase (hold until spi_done).
module flash_seq_ctrl #(
  parameter int unsigned NUM_PAGES  = 4,
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter int unsigned PAGE_BYTES = 256,
  parameter int unsigned ERASE_MODE = 0,
  parameter logic [23:0] POLL_LIMIT = 24'hFFFFFF,
  parameter logic [7:0]  SEED       = 8'h00
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        spi_idle,
  input  logic        spi_done,
  input  logic        w_data_req,
  input  logic        r_data_vld,
  input  logic [7:0]  r_data,
  output logic        spi_start,
  output logic [7:0]  spi_cmd,
  output logic [23:0] spi_addr,
  output logic [8:0]  spi_len,
  output logic [7:0]  spi_wdata,
  output logic        busy,
  output logic        test_done,
  output logic        test_pass,
  output logic        timeout,
  output logic [15:0] err_cnt
);

  localparam logic [15:0] LAST_PAGE  = 16'(NUM_PAGES - 1);
  localparam logic [8:0]  PAGE_LEN   = 9'(PAGE_BYTES);
  localparam bit          CHIP_ERASE = (ERASE_MODE == 1);

  typedef enum logic [2:0] {IDLE, WEL, ERASE, POLL, PROG, READ, NEXT, FIN} state_t;
  typedef enum logic {PH_ISSUE, PH_WAIT} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic        erase_pend_q, erase_pend_d;
  logic [23:0] page_addr_q, page_addr_d;
  logic [15:0] page_idx_q, page_idx_d;
  logic [7:0]  byte_idx_q, byte_idx_d;
  logic [23:0] poll_cnt_q, poll_cnt_d;
  logic        status_wip_q, status_wip_d;
  logic        spi_start_d, busy_d, test_done_d, test_pass_d, timeout_d;
  logic [7:0]  spi_cmd_d, spi_wdata_d;
  logic [23:0] spi_addr_d;
  logic [8:0]  spi_len_d;
  logic [15:0] err_cnt_d;
  logic        wip;
  logic [23:0] poll_inc;
  logic [23:0] next_page_addr;

  function automatic logic [7:0] pattern(input logic [7:0] k, input logic [7:0] p);
    return SEED + k + p;
  endfunction

  // A status byte arriving in the same cycle as spi_done still decides the poll.
  assign wip            = r_data_vld ? r_data[0] : status_wip_q;
  assign poll_inc       = poll_cnt_q + 24'd1;
  assign next_page_addr = page_addr_q + 24'd256;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    erase_pend_d = erase_pend_q;
    page_addr_d  = page_addr_q;
    page_idx_d   = page_idx_q;
    byte_idx_d   = byte_idx_q;
    poll_cnt_d   = poll_cnt_q;
    status_wip_d = status_wip_q;
    spi_start_d  = 1'b0;
    spi_cmd_d    = spi_cmd;
    spi_addr_d   = spi_addr;
    spi_len_d    = spi_len;
    spi_wdata_d  = spi_wdata;
    busy_d       = busy;
    test_done_d  = 1'b0;
    test_pass_d  = test_pass;
    timeout_d    = timeout;
    err_cnt_d    = err_cnt;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = WEL;
          phase_d      = PH_ISSUE;
          erase_pend_d = 1'b1;
          page_addr_d  = START_ADDR;
          page_idx_d   = '0;
          busy_d       = 1'b1;
          err_cnt_d    = '0;
          timeout_d    = 1'b0;
          test_pass_d  = 1'b0;
        end
      end
      NEXT: begin
        page_addr_d = next_page_addr;
        page_idx_d  = page_idx_q + 16'd1;
        if (page_idx_q == LAST_PAGE) begin
          state_d = FIN;
        end else begin
          state_d      = WEL;
          phase_d      = PH_ISSUE;
          erase_pend_d = !CHIP_ERASE && (next_page_addr[11:0] == 12'h000);
        end
      end
      FIN: begin
        test_done_d = 1'b1;
        test_pass_d = !timeout && (err_cnt == 16'h0000);
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        if (phase_q == PH_ISSUE) begin
          if (spi_idle) begin
            spi_start_d = 1'b1;
            phase_d     = PH_WAIT;
            case (state_q)
              WEL: begin
                spi_cmd_d  = 8'h06;
                spi_addr_d = '0;
                spi_len_d  = '0;
              end
              ERASE: begin
                spi_cmd_d  = CHIP_ERASE ? 8'hC7 : 8'h20;
                spi_addr_d = CHIP_ERASE ? 24'h000000 : (page_addr_q & 24'hFFF000);
                spi_len_d  = '0;
              end
              POLL: begin
                spi_cmd_d    = 8'h05;
                spi_addr_d   = '0;
                spi_len_d    = 9'd1;
                status_wip_d = 1'b1;
              end
              PROG: begin
                spi_cmd_d  = 8'h02;
                spi_addr_d = page_addr_q;
                spi_len_d  = PAGE_LEN;
              end
              READ: begin
                spi_cmd_d  = 8'h03;
                spi_addr_d = page_addr_q;
                spi_len_d  = PAGE_LEN;
              end
              default: ;
            endcase
          end
        end else begin
          case (state_q)
            WEL: begin
              if (spi_done) begin
                phase_d = PH_ISSUE;
                if (erase_pend_q) begin
                  state_d = ERASE;
                end else begin
                  state_d     = PROG;
                  byte_idx_d  = '0;
                  spi_wdata_d = pattern(8'd0, page_idx_q[7:0]);
                end
              end
            end
            ERASE: begin
              if (spi_done) begin
                state_d    = POLL;
                phase_d    = PH_ISSUE;
                poll_cnt_d = '0;
              end
            end
            POLL: begin
              if (r_data_vld) status_wip_d = r_data[0];
              if (spi_done) begin
                if (!wip) begin
                  phase_d    = PH_ISSUE;
                  poll_cnt_d = '0;
                  if (erase_pend_q) begin
                    erase_pend_d = 1'b0;
                    state_d      = WEL;
                  end else begin
                    state_d    = READ;
                    byte_idx_d = '0;
                  end
                end else if (poll_inc == POLL_LIMIT) begin
                  timeout_d = 1'b1;
                  state_d   = FIN;
                end else begin
                  poll_cnt_d = poll_inc;
                  phase_d    = PH_ISSUE;
                end
              end
            end
            PROG: begin
              if (w_data_req) begin
                byte_idx_d  = byte_idx_q + 8'd1;
                spi_wdata_d = pattern(byte_idx_q + 8'd1, page_idx_q[7:0]);
              end
              if (spi_done) begin
                state_d    = POLL;
                phase_d    = PH_ISSUE;
                poll_cnt_d = '0;
              end
            end
            READ: begin
              if (r_data_vld) begin
                byte_idx_d = byte_idx_q + 8'd1;
                if ((r_data != pattern(byte_idx_q, page_idx_q[7:0])) && (err_cnt != 16'hFFFF))
                  err_cnt_d = err_cnt + 16'd1;
              end
              if (spi_done) state_d = NEXT;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      phase_q      <= PH_ISSUE;
      erase_pend_q <= 1'b0;
      page_addr_q  <= '0;
      page_idx_q   <= '0;
      byte_idx_q   <= '0;
      poll_cnt_q   <= '0;
      status_wip_q <= 1'b0;
      spi_start    <= 1'b0;
      spi_cmd      <= '0;
      spi_addr     <= '0;
      spi_len      <= '0;
      spi_wdata    <= '0;
      busy         <= 1'b0;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      timeout      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      erase_pend_q <= erase_pend_d;
      page_addr_q  <= page_addr_d;
      page_idx_q   <= page_idx_d;
      byte_idx_q   <= byte_idx_d;
      poll_cnt_q   <= poll_cnt_d;
      status_wip_q <= status_wip_d;
      spi_start    <= spi_start_d;
      spi_cmd      <= spi_cmd_d;
      spi_addr     <= spi_addr_d;
      spi_len      <= spi_len_d;
      spi_wdata    <= spi_wdata_d;
      busy         <= busy_d;
      test_done    <= test_done_d;
      test_pass    <= test_pass_d;
      timeout      <= timeout_d;
      err_cnt      <= err_cnt_d;
    end
  end

endmodule
